// File: rtl/dbg_pkg.sv
// Shared definitions for the debug run-control block: run-state encodings
// and a ceiling-log2 helper used to size breakpoint indices.
package dbg_pkg;

  typedef enum logic [1:0] {
    S_PAUSE = 2'd0,
    S_STEP  = 2'd1,
    S_CONT  = 2'd2,
    S_RUNN  = 2'd3
  } state_e;

  // Index width for n entries; a single entry still needs one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/dbg_brk_match.sv
// Breakpoint comparator array with lowest-index priority encoding.
// Purely combinational; the caller qualifies the result with its skip flag.
module dbg_brk_match
  import dbg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_BRK = 4,
  parameter int IDX_W   = clog2(NUM_BRK)
) (
  input  logic [XLEN-1:0]               pc,
  input  logic [NUM_BRK-1:0][XLEN-1:0]  addr,
  input  logic [NUM_BRK-1:0]            valid,
  output logic                          match,
  output logic [IDX_W-1:0]              idx
);

  // Scanning from the top down lets the lowest matching entry win last.
  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    match = 1'b0;
    idx   = '0;
    for (int i = NUM_BRK - 1; i >= 0; i--) begin
      if (valid[i] && (addr[i] == pc)) begin
        match = 1'b1;
        idx   = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dbg_run_ctrl.sv
// CPU run-control: gates the core with clk_en in step / continuous / run-N
// modes and stops on address breakpoints. Optional cycle counter under
// DBG_CYCLE_CNT_EN.
module dbg_run_ctrl
  import dbg_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_BRK = 4,
  parameter int STEP_W  = 8,
  parameter int IDX_W   = clog2(NUM_BRK)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               cont,
  input  logic               run_n,
  input  logic [STEP_W-1:0]  step_cnt_in,
  input  logic               halt,
  input  logic               brk_set,
  input  logic               brk_clr,
  input  logic [IDX_W-1:0]   brk_idx,
  input  logic [XLEN-1:0]    brk_addr_in,
  input  logic [XLEN-1:0]    pc,
  output logic               clk_en,
  output logic [1:0]         mode,
  output logic               pause,
  output logic [NUM_BRK-1:0] brk_valid,
  output logic               brk_hit,
  output logic [IDX_W-1:0]   brk_hit_idx
`ifdef DBG_CYCLE_CNT_EN
  ,
  output logic [31:0]        cyc_cnt
`endif
);

  state_e                      state_q, state_d;
  logic [STEP_W-1:0]           cnt_q, cnt_d;
  logic                        skip_q, skip_d;
  logic                        hit_d;
  logic [NUM_BRK-1:0][XLEN-1:0] addr_q;
  logic [NUM_BRK-1:0]          valid_q;
  logic                        match;
  logic [IDX_W-1:0]            match_idx;
  logic                        stop;

  dbg_brk_match #(
    .XLEN    (XLEN),
    .NUM_BRK (NUM_BRK),
    .IDX_W   (IDX_W)
  ) u_match (
    .pc    (pc),
    .addr  (addr_q),
    .valid (valid_q),
    .match (match),
    .idx   (match_idx)
  );

  assign stop = match && !skip_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    skip_d  = skip_q;
    hit_d   = 1'b0;
    clk_en  = 1'b0;
    unique case (state_q)
      S_PAUSE: begin
        if (!halt) begin
          if (step) begin
            state_d = S_STEP;
            skip_d  = 1'b1;
          end else if (cont) begin
            state_d = S_CONT;
            skip_d  = 1'b1;
          end else if (run_n && (step_cnt_in != '0)) begin
            state_d = S_RUNN;
            cnt_d   = step_cnt_in;
            skip_d  = 1'b1;
          end
        end
      end
      S_STEP: begin
        // A single step always executes; only halt can suppress it.
        clk_en  = !halt;
        state_d = (!halt && cont) ? S_CONT : S_PAUSE;
      end
      S_CONT: begin
        if (halt) begin
          state_d = S_PAUSE;
        end else if (stop) begin
          state_d = S_PAUSE;
          hit_d   = 1'b1;
        end else begin
          clk_en = 1'b1;
        end
      end
      S_RUNN: begin
        if (halt) begin
          state_d = S_PAUSE;
        end else if (stop) begin
          state_d = S_PAUSE;
          hit_d   = 1'b1;
        end else begin
          clk_en = 1'b1;
          cnt_d  = cnt_q - STEP_W'(1);
          if (cnt_q == STEP_W'(1)) state_d = S_PAUSE;
        end
      end
    endcase
    // Skip covers only the first executed cycle after a resume.
    if (clk_en) skip_d = 1'b0;
    if (rst)    clk_en = 1'b0;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_PAUSE;
      cnt_q       <= '0;
      skip_q      <= 1'b0;
      brk_hit     <= 1'b0;
      brk_hit_idx <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      brk_hit <= hit_d;
      if (hit_d) brk_hit_idx <= match_idx;
    end
  end

  // NOTE: the breakpoint table is small and its addresses are visible to the
  // comparator, so it is reset explicitly rather than left as uninitialised RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      valid_q <= '0;
    end else if ((state_q == S_PAUSE) && (int'(brk_idx) < NUM_BRK)) begin
      if (brk_clr) begin
        valid_q[brk_idx] <= 1'b0;
      end else if (brk_set) begin
        valid_q[brk_idx] <= 1'b1;
        addr_q[brk_idx]  <= brk_addr_in;
      end
    end
  end

`ifdef DBG_CYCLE_CNT_EN
  // Simultaneous set+clr while paused doubles as a counter clear strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt <= '0;
    end else if ((state_q == S_PAUSE) && brk_set && brk_clr) begin
      cyc_cnt <= '0;
    end else if (clk_en) begin
      cyc_cnt <= cyc_cnt + 32'd1;
    end
  end
`endif

  assign mode      = state_q;
  assign pause     = (state_q == S_PAUSE);
  assign brk_valid = valid_q;

endmodule

// File: tb/tb_dbg_run_ctrl.sv
// Directed self-checking bench for dbg_run_ctrl; the bench plays the CPU by
// advancing pc by 4 on every cycle in which clk_en was high.
module tb_dbg_run_ctrl;
  import dbg_pkg::*;

  localparam int XLEN    = 32;
  localparam int NUM_BRK = 4;
  localparam int STEP_W  = 8;
  localparam int IDX_W   = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               step, cont, run_n, halt, brk_set, brk_clr;
  logic [STEP_W-1:0]  step_cnt_in;
  logic [IDX_W-1:0]   brk_idx;
  logic [XLEN-1:0]    brk_addr_in, pc;
  logic               clk_en, pause, brk_hit;
  logic [1:0]         mode;
  logic [NUM_BRK-1:0] brk_valid;
  logic [IDX_W-1:0]   brk_hit_idx;
`ifdef DBG_CYCLE_CNT_EN
  logic [31:0]        cyc_cnt;
`endif

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  dbg_run_ctrl #(
    .XLEN(XLEN), .NUM_BRK(NUM_BRK), .STEP_W(STEP_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst(rst), .step(step), .cont(cont), .run_n(run_n),
    .step_cnt_in(step_cnt_in), .halt(halt), .brk_set(brk_set),
    .brk_clr(brk_clr), .brk_idx(brk_idx), .brk_addr_in(brk_addr_in),
    .pc(pc), .clk_en(clk_en), .mode(mode), .pause(pause),
    .brk_valid(brk_valid), .brk_hit(brk_hit), .brk_hit_idx(brk_hit_idx)
`ifdef DBG_CYCLE_CNT_EN
    , .cyc_cnt(cyc_cnt)
`endif
  );

  // Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Runs the CPU until clk_en drops (or the budget expires); returns enabled cycles.
  task automatic run_until_stop(input int budget, output int n);
    bit en;
    n = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      en = clk_en;
      if (!en) break;
      n++;
      next();
      pc = pc + 32'd4;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    next(); next();
    @(negedge clk);
    total++; if (clk_en !== 1'b0) $display("FAIL rst_clk_en: got %b want 0", clk_en); else pass_cnt++;
    next();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mode !== 2'd0 || pause !== 1'b1 || brk_valid !== 4'b0000 || brk_hit !== 1'b0 || brk_hit_idx !== 2'd0)
      $display("FAIL reset_state: mode=%0d pause=%b valid=%b hit=%b idx=%0d want 0 1 0000 0 0",
               mode, pause, brk_valid, brk_hit, brk_hit_idx);
    else pass_cnt++;
    next();
  endtask

  task automatic test_step();
    pc = 32'h0;
    step = 1'b1;
    @(negedge clk);
    total++; if (clk_en !== 1'b0) $display("FAIL step_pause_en: got %b want 0", clk_en); else pass_cnt++;
    next();
    step = 1'b0;
    @(negedge clk);
    total++;
    if (clk_en !== 1'b1 || mode !== 2'd1 || pause !== 1'b0)
      $display("FAIL step_active: en=%b mode=%0d pause=%b want 1 1 0", clk_en, mode, pause);
    else pass_cnt++;
    next();
    pc = pc + 32'd4;
    @(negedge clk);
    total++;
    if (clk_en !== 1'b0 || mode !== 2'd0 || pause !== 1'b1)
      $display("FAIL step_done: en=%b mode=%0d pause=%b want 0 0 1", clk_en, mode, pause);
    else pass_cnt++;
    next();
  endtask

  task automatic test_step_to_cont();
    step = 1'b1;
    next();
    step = 1'b0;
    cont = 1'b1;
    next();
    cont = 1'b0;
    pc = pc + 32'd4;
    @(negedge clk);
    total++;
    if (mode !== 2'd2 || clk_en !== 1'b1)
      $display("FAIL step_to_cont: mode=%0d en=%b want 2 1", mode, clk_en);
    else pass_cnt++;
    halt = 1'b1;
    next();
    halt = 1'b0;
  endtask

  task automatic test_brk_cont();
    int n;
    brk_set = 1'b1; brk_idx = 2'd2; brk_addr_in = 32'h10;
    next();
    brk_set = 1'b0;
    @(negedge clk);
    total++; if (brk_valid !== 4'b0100) $display("FAIL brk_set2: got %b want 0100", brk_valid); else pass_cnt++;
    next();
    pc = 32'h0;
    cont = 1'b1;
    next();
    cont = 1'b0;
    run_until_stop(20, n);
    total++;
    if (n !== 4 || pc !== 32'h10)
      $display("FAIL brk_stop: cycles=%0d pc=%h want 4 00000010", n, pc);
    else pass_cnt++;
    next();
    @(negedge clk);
    total++;
    if (brk_hit !== 1'b1 || brk_hit_idx !== 2'd2 || mode !== 2'd0)
      $display("FAIL brk_hit: hit=%b idx=%0d mode=%0d want 1 2 0", brk_hit, brk_hit_idx, mode);
    else pass_cnt++;
    next();
    @(negedge clk);
    total++; if (brk_hit !== 1'b0) $display("FAIL brk_hit_pulse: got %b want 0", brk_hit); else pass_cnt++;
    next();
  endtask

  task automatic test_skip_resume();
    cont = 1'b1;
    next();
    cont = 1'b0;
    @(negedge clk);
    total++; if (clk_en !== 1'b1) $display("FAIL skip_first: got %b want 1", clk_en); else pass_cnt++;
    next();
    pc = pc + 32'd4;
    @(negedge clk);
    total++;
    if (clk_en !== 1'b1 || mode !== 2'd2 || pc !== 32'h14)
      $display("FAIL skip_running: en=%b mode=%0d pc=%h want 1 2 00000014", clk_en, mode, pc);
    else pass_cnt++;
    next();
    pc = pc + 32'd4;
    halt = 1'b1;
    @(negedge clk);
    total++; if (clk_en !== 1'b0) $display("FAIL halt_cont_en: got %b want 0", clk_en); else pass_cnt++;
    next();
    halt = 1'b0;
    @(negedge clk);
    total++;
    if (mode !== 2'd0 || brk_hit !== 1'b0)
      $display("FAIL halt_cont: mode=%0d hit=%b want 0 0", mode, brk_hit);
    else pass_cnt++;
    next();
  endtask

  task automatic test_run_n();
    int n;
    brk_clr = 1'b1; brk_idx = 2'd2;
    next();
    brk_clr = 1'b0;
    pc = 32'h100;
    step_cnt_in = 8'd5; run_n = 1'b1;
    next();
    run_n = 1'b0;
    run_until_stop(20, n);
    total++;
    if (n !== 5 || mode !== 2'd0)
      $display("FAIL run_n5: cycles=%0d mode=%0d want 5 0", n, mode);
    else pass_cnt++;
    next();
    step_cnt_in = 8'd0; run_n = 1'b1;
    next();
    run_n = 1'b0;
    @(negedge clk);
    total++;
    if (clk_en !== 1'b0 || mode !== 2'd0)
      $display("FAIL run_n0: en=%b mode=%0d want 0 0", clk_en, mode);
    else pass_cnt++;
    next();
  endtask

  task automatic test_priority_idx();
    int n;
    brk_set = 1'b1; brk_idx = 2'd1; brk_addr_in = 32'h20;
    next();
    brk_idx = 2'd3;
    next();
    brk_set = 1'b0;
    @(negedge clk);
    total++; if (brk_valid !== 4'b1010) $display("FAIL brk_set13: got %b want 1010", brk_valid); else pass_cnt++;
    next();
    pc = 32'h18;
    cont = 1'b1;
    next();
    cont = 1'b0;
    run_until_stop(20, n);
    next();
    @(negedge clk);
    total++;
    if (n !== 2 || brk_hit !== 1'b1 || brk_hit_idx !== 2'd1)
      $display("FAIL brk_lowest: cycles=%0d hit=%b idx=%0d want 2 1 1", n, brk_hit, brk_hit_idx);
    else pass_cnt++;
    next();
    brk_set = 1'b1; brk_clr = 1'b1; brk_idx = 2'd1; brk_addr_in = 32'h40;
    next();
    brk_set = 1'b0; brk_clr = 1'b0;
    @(negedge clk);
    total++; if (brk_valid !== 4'b1000) $display("FAIL set_clr_same: got %b want 1000", brk_valid); else pass_cnt++;
    next();
    // Resume from pc 0x20 (entry 3); attempt a table write while running.
    cont = 1'b1;
    next();
    cont = 1'b0;
    brk_set = 1'b1; brk_idx = 2'd0; brk_addr_in = 32'h24;
    next();
    brk_set = 1'b0;
    pc = pc + 32'd4;
    @(negedge clk);
    total++;
    if (clk_en !== 1'b1 || mode !== 2'd2)
      $display("FAIL set_in_cont_run: en=%b mode=%0d want 1 2", clk_en, mode);
    else pass_cnt++;
    halt = 1'b1;
    next();
    halt = 1'b0;
    @(negedge clk);
    total++; if (brk_valid !== 4'b1000) $display("FAIL set_in_cont: got %b want 1000", brk_valid); else pass_cnt++;
    next();
  endtask

  task automatic test_halt_runn();
    int n;
    brk_clr = 1'b1; brk_idx = 2'd3;
    next();
    brk_clr = 1'b0;
    pc = 32'h200;
    step_cnt_in = 8'd5; run_n = 1'b1;
    next();
    run_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      next();
      pc = pc + 32'd4;
    end
    halt = 1'b1;
    @(negedge clk);
    total++; if (clk_en !== 1'b0) $display("FAIL halt_runn_en: got %b want 0", clk_en); else pass_cnt++;
    next();
    halt = 1'b0;
    @(negedge clk);
    total++;
    if (mode !== 2'd0 || brk_hit !== 1'b0 || pc !== 32'h208)
      $display("FAIL halt_runn: mode=%0d hit=%b pc=%h want 0 0 00000208", mode, brk_hit, pc);
    else pass_cnt++;
    next();
    step_cnt_in = 8'd2; run_n = 1'b1;
    next();
    run_n = 1'b0;
    run_until_stop(20, n);
    total++; if (n !== 2) $display("FAIL run_n_reload: cycles=%0d want 2", n); else pass_cnt++;
    next();
  endtask

  task automatic test_reset_in_cont();
    brk_set = 1'b1; brk_idx = 2'd0; brk_addr_in = 32'h999;
    next();
    brk_set = 1'b0;
    cont = 1'b1;
    next();
    cont = 1'b0;
    next();
    pc = pc + 32'd4;
    rst = 1'b1;
    @(negedge clk);
    total++; if (clk_en !== 1'b0) $display("FAIL rst_cont_en: got %b want 0", clk_en); else pass_cnt++;
    next();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (mode !== 2'd0 || pause !== 1'b1 || brk_valid !== 4'b0000 || brk_hit !== 1'b0 ||
        brk_hit_idx !== 2'd0 || clk_en !== 1'b0)
      $display("FAIL rst_cont: mode=%0d pause=%b valid=%b hit=%b idx=%0d en=%b want 0 1 0000 0 0 0",
               mode, pause, brk_valid, brk_hit, brk_hit_idx, clk_en);
    else pass_cnt++;
    next();
  endtask

  initial begin
    step = 0; cont = 0; run_n = 0; halt = 0; brk_set = 0; brk_clr = 0;
    step_cnt_in = '0; brk_idx = '0; brk_addr_in = '0; pc = '0; rst = 1'b1;
    test_reset();
    test_step();
    test_step_to_cont();
    test_brk_cont();
    test_skip_resume();
    test_run_n();
    test_priority_idx();
    test_halt_runn();
    test_reset_in_cont();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
